// File: rtl/if_stage_pkg.sv
// Shared definitions for the MIPS pipeline front end: instruction constants,
// opcode encodings and the IF/ID register payload.
package if_stage_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ANDI  = 6'h0C,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: hold freezes the contents, flush replaces the
// instruction with a NOP bubble while still recording the sequential PC+4.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IF_ID_RESET;
    end else if (hold) begin
      q <= q;
    end else if (flush) begin
      q <= '{instr: NOP_INSTR, pc4: d.pc4, valid: 1'b0};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection for stall/branch/
// jump, IF/ID register and saturating stall/flush event counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instru,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        redirect;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign imem_addr = pc;
  assign pc4       = pc + PC_STEP;
  assign redirect  = branch_taken | jump;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else chain can leave a latch behind.
  always_comb begin
    next_pc = pc4;
    if (stall) begin
      next_pc = pc;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (jump) begin
      next_pc = jump_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else begin
      pc <= next_pc;
    end
  end

  assign if_id_d = '{instr: imem_rdata, pc4: pc4, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (stall),
    .flush (redirect),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_instru = if_id_q.instr;
  assign if_id_pc4    = if_id_q.pc4;
  assign if_id_valid  = if_id_q.valid;

  // A redirect only counts when it is accepted, i.e. not masked by a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!stall && redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-edge vectors plus hand-written
// sequences for asynchronous reset and counter saturation.
module tb_if_stage;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      pc;
  logic [31:0]      if_id_instru;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int passed = 0;
  int total  = 0;

  if_stage #(.PC_RESET(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .if_id_instru  (if_id_instru),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two real program words, otherwise a tag of the address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h8D09_0004;
      default:       return {16'hA000, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] j_tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [15:0] e_scnt;
    logic [15:0] e_fcnt;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid,
                           input logic [15:0] e_scnt, input logic [15:0] e_fcnt);
    check({tag, " pc"},        pc,                  e_pc);
    check({tag, " imem_addr"}, imem_addr,           e_pc);
    check({tag, " instr"},     if_id_instru,        e_instr);
    check({tag, " pc4"},       if_id_pc4,           e_pc4);
    check({tag, " valid"},     {31'h0, if_id_valid}, {31'h0, e_valid});
    check({tag, " stall_cnt"}, {16'h0, stall_cnt},  {16'h0, e_scnt});
    check({tag, " flush_cnt"}, {16'h0, flush_cnt},  {16'h0, e_fcnt});
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
  endtask

  initial begin
    //          stall br  br_tgt        jmp j_tgt          pc            instr         pc4           v  scnt fcnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1'b1, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0008, 32'h8D09_0004, 32'h0000_0008, 1'b1, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_000C, 32'hA000_0008, 32'h0000_000C, 1'b1, 16'd0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h0000_0040, 32'h0000_0000, 32'h0000_0010, 1'b0, 16'd0, 16'd1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0044, 32'hA000_0040, 32'h0000_0044, 1'b1, 16'd0, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       32'h0000_0010, 32'h0000_0000, 32'h0000_0048, 1'b0, 16'd0, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0010, 32'h0000_0000, 32'h0000_0048, 1'b0, 16'd1, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0010, 32'h0000_0000, 32'h0000_0048, 1'b0, 16'd2, 16'd2};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0010, 32'h0000_0000, 32'h0000_0048, 1'b0, 16'd3, 16'd2};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0014, 32'hA000_0010, 32'h0000_0014, 1'b1, 16'd3, 16'd2};
    vecs[10] = '{1'b1, 1'b1, 32'h80,       1'b1, 32'h100,      32'h0000_0014, 32'hA000_0010, 32'h0000_0014, 1'b1, 16'd4, 16'd2};
    vecs[11] = '{1'b0, 1'b1, 32'h80,       1'b1, 32'h100,      32'h0000_0080, 32'h0000_0000, 32'h0000_0018, 1'b0, 16'd4, 16'd3};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0084, 32'hA000_0080, 32'h0000_0084, 1'b1, 16'd4, 16'd3};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h102,      32'h0000_0102, 32'h0000_0000, 32'h0000_0088, 1'b0, 16'd4, 16'd4};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0106, 32'hA000_0102, 32'h0000_0106, 1'b1, 16'd4, 16'd4};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_010A, 1'b0, 16'd4, 16'd5};
    vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0000_0000, 32'hA000_FFFC, 32'h0000_0000, 1'b1, 16'd4, 16'd5};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #12;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);

    // Release away from an edge; outputs must hold until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("post_release", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].br_tgt, vecs[i].jmp, vecs[i].j_tgt);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                vecs[i].e_valid, vecs[i].e_scnt, vecs[i].e_fcnt);
    end

    // Asynchronous reset in the middle of a stall with a pending redirect.
    drive(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check_all("stall_pre_rst", 32'h0, 32'hA000_FFFC, 32'h0, 1'b1, 16'd5, 16'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    @(posedge clk);
    #1;
    check_all("rst_held", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // Long stall: stall_cnt must stop at all-ones rather than wrap.
    repeat ((1 << CNT_W) + 2) @(posedge clk);
    #1;
    check_all("stall_sat", 32'h0, 32'h0, 32'h0, 1'b0, 16'hFFFF, 16'd0);

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check_all("resume", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 16'hFFFF, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
